decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  RV32I pipeline D stage: decodes Instr_D, drives the register-file read addresses, and registers decoded control into the D/E boundary.
//  RF read data is registered on the same posedge, so RdData1/2 and the *_E outputs reach EX aligned.
//  Detects load-use hazards (stall + bubble). Halts issue on ECALL/EBREAK/illegal until Resume.
// PARAMETERS
//  XLEN   32  datapath width
//  RBITS  5   register address width
// PORTS
//  clk         in   1      clock; all state on posedge
//  rst         in   1      synchronous, active-low reset
//  InstrValid_D in  1      Instr_D/PC_D hold a real instruction
//  Instr_D     in   32     instruction from IF/D register
//  PC_D        in   XLEN   PC of Instr_D
//  Flush_E     in   1      taken branch/jump in EX: kill the instruction in D
//  Resume      in   1      one-cycle pulse: leave HALT
//  RdAddress1  out  RBITS  rs1 = Instr_D[19:15], combinational, to RF
//  RdAddress2  out  RBITS  rs2 = Instr_D[24:20], combinational, to RF
//  Stall_D     out  1      combinational; freeze PC and IF/D register
//  Valid_E     out  1      E slot holds a real instruction
//  PC_E        out  XLEN   PC of the E instruction
//  Imm_E       out  XLEN   sign-extended immediate (I/S/B/U/J format)
//  Rs1_E/Rs2_E/Rd_E  out  RBITS  register indices for forwarding and writeback
//  ALUCtrl_E   out  4      0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  ALUSrcA_E   out  1      0 rs1, 1 PC (AUIPC)
//  ALUSrcB_E   out  1      0 rs2, 1 Imm
//  MemRead_E/MemWrite_E/RegWrite_E  out  1  enables
//  ResultSrc_E out  2      0 ALU, 1 memory, 2 PC+4
//  Branch_E/Jump_E/JumpReg_E  out  1  BRANCH / JAL / JALR
//  Funct3_E    out  3      branch condition or load/store size
//  Halt_E/IllegalInstr_E  out  1  system op / unknown opcode in E
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all *_E outputs 0; FSM in RUN. Stall_D is 0 while in reset.
//  - Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
//    - MISC-MEM decodes as NOP (Valid_E=1, no enables).
//    - Any other opcode: IllegalInstr_E=1 and all enables 0.
//  - Field decode:
//    - OP uses funct7[5] to select SUB/SRA. OP-IMM uses funct7[5] only for shifts.
//    - LUI uses PASSB with the U-immediate.
//    - RegWrite_E=0 when Rd=0.
//  - Operand use:
//    - uses_rs1 = !(LUI|AUIPC|JAL).
//    - uses_rs2 = BRANCH|STORE|OP.
//  - Load-use hazard: hz = Valid_E & MemRead_E & Rd_E!=0 & ((uses_rs1 & Rd_E==rs1) | (uses_rs2 & Rd_E==rs2)).
//  - FSM:
//    - RUN:
//      - If Flush_E: bubble into E, Stall_D=0.
//      - Else if hz: Stall_D=1, bubble into E; the next cycle re-decodes the same instruction.
//      - Else: issue D->E.
//      - If the issued instruction is SYSTEM or illegal: go to HALT.
//    - HALT:
//      - Stall_D=1 and bubbles every cycle.
//      - Resume=1: go to RUN with Stall_D=0 in that cycle.
//      - Flush_E in HALT: go to RUN.
//  - Bubble: Valid_E and every enable/Halt/Illegal bit 0. Other *_E fields are don't-care.
//  - Simultaneous events:
//    - Flush_E beats hz beats issue.
//    - InstrValid_D=0 acts as a bubble with no hazard.
//  - RF writes occur on negedge, so a WB write to rs is visible to this read; no WB->D bypass is required.
//  - Reset mid-stall or mid-HALT: returns to RUN and E is empty next cycle.
// STRUCTURE
//  - Shared package: opcode localparams, ALUCtrl and ResultSrc encodings.
//  - Sub-module imm_gen: combinational Instr -> XLEN immediate, format selected by opcode.
//  - Top module holds the decoder, hazard logic, 2-state FSM and the D/E register.
// TESTING
//  T1 reset: rst=0 for 2 clk -> all *_E=0, Stall_D=0; FSM in RUN after release.
//  T2 ADDI x1,x0,5 (0x00500093): next cycle -> Valid_E=1, Rd_E=1, Imm_E=5, ALUCtrl_E=0, ALUSrcB_E=1, RegWrite_E=1.
//  T3 load-use, LW x2,0(x1) (0x0000A103) then ADD x3,x2,x2 (0x002101B3):
//     -> Stall_D=1 for exactly 1 cycle, one bubble, then ADD issued with Rs1_E=Rs2_E=2.
//     Repeat with SW x2,0(x0) (0x00202023) in place of the ADD -> stall (rs2 use).
//     Repeat with LUI x2 in place of the ADD -> no stall.
//  T4 Flush_E=1 in the hazard cycle -> Stall_D=0, Valid_E=0 next cycle.
//     Flush_E=1 on a plain ADDI -> ADDI not issued.
//  T5 ECALL (0x00000073) -> Halt_E=1 one cycle, then Stall_D=1 and bubbles.
//     Resume pulse after 5 cycles -> the next instruction issues 1 cycle later.
//     rst=0 during HALT -> RUN.
//  T6 0x0000007F -> IllegalInstr_E=1, RegWrite_E=MemWrite_E=0, FSM enters HALT.
//     ADD with rd=x0 -> RegWrite_E=0.

Source files
------------

// File: rtl/decode_issue_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU/result encodings, FSM states
// and the packed control bundle carried across the D/E boundary.
package decode_issue_stage_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } issue_state_e;

  // Everything a bubble must clear lives in this bundle, so a bubble is '0.
  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    result_src_e result_src;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        halt;
    logic        illegal;
  } ctrl_t;

  // Shared by OP and OP-IMM; 'alt' is the funct7[5] qualifier, already
  // masked by the caller where it must not apply (ADDI with a negative imm).
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_issue_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the opcode and
// sign-extends to XLEN. Opcodes without an immediate fall back to I-type.
module imm_gen
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Format select and bit scatter for the 32-bit immediate.
  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: imm32 = {instr[31:12], 12'b0};
      OP_JAL:           imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
      OP_BRANCH:        imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
      OP_STORE:         imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      default:          imm32 = {{21{instr[31]}}, instr[30:20]};
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes Instr_D, drives RF read addresses,
// detects load-use hazards and registers decoded control into the D/E slot.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal issue; Flush_E > load-use stall > issue
//   ST_HALT | SYSTEM/illegal op issued; stall D and bubble E until
//           | Resume (issue resumes that cycle) or Flush_E
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RBITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InstrValid_D,
  input  logic [31:0]      Instr_D,
  input  logic [XLEN-1:0]  PC_D,
  input  logic             Flush_E,
  input  logic             Resume,
  output logic [RBITS-1:0] RdAddress1,
  output logic [RBITS-1:0] RdAddress2,
  output logic             Stall_D,
  output logic             Valid_E,
  output logic [XLEN-1:0]  PC_E,
  output logic [XLEN-1:0]  Imm_E,
  output logic [RBITS-1:0] Rs1_E,
  output logic [RBITS-1:0] Rs2_E,
  output logic [RBITS-1:0] Rd_E,
  output logic [3:0]       ALUCtrl_E,
  output logic             ALUSrcA_E,
  output logic             ALUSrcB_E,
  output logic             MemRead_E,
  output logic             MemWrite_E,
  output logic             RegWrite_E,
  output logic [1:0]       ResultSrc_E,
  output logic             Branch_E,
  output logic             Jump_E,
  output logic             JumpReg_E,
  output logic [2:0]       Funct3_E,
  output logic             Halt_E,
  output logic             IllegalInstr_E
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [RBITS-1:0] rs1;
  logic [RBITS-1:0] rs2;
  logic [RBITS-1:0] rd;
  logic [XLEN-1:0]  imm_d;
  ctrl_t            dec_ctrl;

  logic             uses_rs1;
  logic             uses_rs2;
  logic             load_use;

  issue_state_e     state;
  issue_state_e     state_nxt;
  logic             stall_raw;
  logic             issue;

  logic             e_valid;
  logic [XLEN-1:0]  e_pc;
  logic [XLEN-1:0]  e_imm;
  logic [RBITS-1:0] e_rs1;
  logic [RBITS-1:0] e_rs2;
  logic [RBITS-1:0] e_rd;
  logic [2:0]       e_funct3;
  ctrl_t            e_ctrl;

  assign opcode = Instr_D[6:0];
  assign funct3 = Instr_D[14:12];
  assign rd     = Instr_D[7 +: RBITS];
  assign rs1    = Instr_D[15 +: RBITS];
  assign rs2    = Instr_D[20 +: RBITS];

  // The RF registers its read data on the same edge as the D/E slot, so
  // these go straight from the instruction word.
  assign RdAddress1 = rs1;
  assign RdAddress2 = rs2;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (Instr_D),
    .imm   (imm_d)
  );

  // Main control decode; unknown opcodes raise illegal with every enable low.
  always_comb begin
    dec_ctrl = '0;
    case (opcode)
      OP_LUI: begin
        dec_ctrl.alu_ctrl  = ALU_PASSB;
        dec_ctrl.alu_src_b = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec_ctrl.alu_src_a = 1'b1;
        dec_ctrl.alu_src_b = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl.alu_src_b  = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = RES_PC4;
        dec_ctrl.jump       = 1'b1;
      end
      OP_JALR: begin
        dec_ctrl.alu_src_b  = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = RES_PC4;
        dec_ctrl.jump_reg   = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl.alu_ctrl = ALU_SUB;
        dec_ctrl.branch   = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl.alu_src_b  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec_ctrl.alu_src_b = 1'b1;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_IMM: begin
        // funct7[5] is immediate data except for the SRLI/SRAI pair.
        dec_ctrl.alu_ctrl  = alu_from_funct3(funct3,
                                             Instr_D[30] & (funct3 == 3'b101));
        dec_ctrl.alu_src_b = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_OP: begin
        dec_ctrl.alu_ctrl  = alu_from_funct3(funct3, Instr_D[30]);
        dec_ctrl.reg_write = 1'b1;
      end
      OP_MISC_MEM: begin
        // FENCE has nothing to do in an in-order core: plain NOP.
      end
      OP_SYSTEM: begin
        dec_ctrl.halt = 1'b1;
      end
      default: begin
        dec_ctrl.illegal = 1'b1;
      end
    endcase
    if (rd == '0) begin
      dec_ctrl.reg_write = 1'b0;
    end
  end

  // Load-use detection against the load currently sitting in E.
  always_comb begin
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);
    load_use = InstrValid_D & e_valid & e_ctrl.mem_read & (e_rd != '0) &
               ((uses_rs1 & (e_rd == rs1)) | (uses_rs2 & (e_rd == rs2)));
  end

  // Issue FSM next-state and stall/issue decision.
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_RUN: begin
        if (Flush_E) begin
          issue = 1'b0;
        end else if (load_use) begin
          stall_raw = 1'b1;
        end else begin
          issue = InstrValid_D;
        end
      end
      ST_HALT: begin
        if (Flush_E) begin
          state_nxt = ST_RUN;
        end else if (Resume) begin
          // E only holds bubbles here, so no hazard can be pending.
          state_nxt = ST_RUN;
          issue     = InstrValid_D;
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    if (issue && (dec_ctrl.halt || dec_ctrl.illegal)) begin
      state_nxt = ST_HALT;
    end
  end

  // IF must not be frozen while the pipeline is being reset.
  assign Stall_D = rst & stall_raw;

  // State register and D/E slot; a bubble clears the whole slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_RUN;
      e_valid  <= 1'b0;
      e_pc     <= '0;
      e_imm    <= '0;
      e_rs1    <= '0;
      e_rs2    <= '0;
      e_rd     <= '0;
      e_funct3 <= '0;
      e_ctrl   <= '0;
    end else begin
      state    <= state_nxt;
      e_valid  <= issue;
      e_pc     <= issue ? PC_D     : '0;
      e_imm    <= issue ? imm_d    : '0;
      e_rs1    <= issue ? rs1      : '0;
      e_rs2    <= issue ? rs2      : '0;
      e_rd     <= issue ? rd       : '0;
      e_funct3 <= issue ? funct3   : '0;
      e_ctrl   <= issue ? dec_ctrl : '0;
    end
  end

  assign Valid_E        = e_valid;
  assign PC_E           = e_pc;
  assign Imm_E          = e_imm;
  assign Rs1_E          = e_rs1;
  assign Rs2_E          = e_rs2;
  assign Rd_E           = e_rd;
  assign Funct3_E       = e_funct3;
  assign ALUCtrl_E      = e_ctrl.alu_ctrl;
  assign ALUSrcA_E      = e_ctrl.alu_src_a;
  assign ALUSrcB_E      = e_ctrl.alu_src_b;
  assign MemRead_E      = e_ctrl.mem_read;
  assign MemWrite_E     = e_ctrl.mem_write;
  assign RegWrite_E     = e_ctrl.reg_write;
  assign ResultSrc_E    = e_ctrl.result_src;
  assign Branch_E       = e_ctrl.branch;
  assign Jump_E         = e_ctrl.jump;
  assign JumpReg_E      = e_ctrl.jump_reg;
  assign Halt_E         = e_ctrl.halt;
  assign IllegalInstr_E = e_ctrl.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: stimulus pushes the expected E-slot
// contents, a negedge monitor pops and compares whenever Valid_E is seen.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstrValid_D;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic        Flush_E;
  logic        Resume;
  logic [4:0]  RdAddress1, RdAddress2;
  logic        Stall_D, Valid_E;
  logic [31:0] PC_E, Imm_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E;
  logic [3:0]  ALUCtrl_E;
  logic        ALUSrcA_E, ALUSrcB_E, MemRead_E, MemWrite_E, RegWrite_E;
  logic [1:0]  ResultSrc_E;
  logic        Branch_E, Jump_E, JumpReg_E;
  logic [2:0]  Funct3_E;
  logic        Halt_E, IllegalInstr_E;

  decode_issue_stage #(.XLEN(32), .RBITS(5)) dut (
    .clk(clk), .rst(rst), .InstrValid_D(InstrValid_D), .Instr_D(Instr_D),
    .PC_D(PC_D), .Flush_E(Flush_E), .Resume(Resume),
    .RdAddress1(RdAddress1), .RdAddress2(RdAddress2), .Stall_D(Stall_D),
    .Valid_E(Valid_E), .PC_E(PC_E), .Imm_E(Imm_E), .Rs1_E(Rs1_E),
    .Rs2_E(Rs2_E), .Rd_E(Rd_E), .ALUCtrl_E(ALUCtrl_E),
    .ALUSrcA_E(ALUSrcA_E), .ALUSrcB_E(ALUSrcB_E), .MemRead_E(MemRead_E),
    .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E),
    .ResultSrc_E(ResultSrc_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
    .JumpReg_E(JumpReg_E), .Funct3_E(Funct3_E), .Halt_E(Halt_E),
    .IllegalInstr_E(IllegalInstr_E)
  );

  always #5 clk = ~clk;

  // {MemRead, MemWrite, RegWrite, ResultSrc[1:0], Branch, Jump, JumpReg, Halt, Illegal}
  logic [9:0] ctl_now;
  assign ctl_now = {MemRead_E, MemWrite_E, RegWrite_E, ResultSrc_E,
                    Branch_E, Jump_E, JumpReg_E, Halt_E, IllegalInstr_E};

  localparam bit [5:0] M_IMM = 6'b100000;
  localparam bit [5:0] M_ALU = 6'b010000;
  localparam bit [5:0] M_RS1 = 6'b001000;
  localparam bit [5:0] M_RS2 = 6'b000100;
  localparam bit [5:0] M_RD  = 6'b000010;
  localparam bit [5:0] M_F3  = 6'b000001;

  localparam logic [31:0] I_ADDI1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_LW     = 32'h0000A103; // lw   x2,0(x1)
  localparam logic [31:0] I_ADD    = 32'h002101B3; // add  x3,x2,x2
  localparam logic [31:0] I_SW     = 32'h00202023; // sw   x2,0(x0)
  localparam logic [31:0] I_LUI    = 32'h00011137; // lui  x2,0x11 (rs1 field = 2)
  localparam logic [31:0] I_SUB    = 32'h40208233; // sub  x4,x1,x2
  localparam logic [31:0] I_SRAI   = 32'h4030D293; // srai x5,x1,3
  localparam logic [31:0] I_BEQ    = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_JAL    = 32'h010000EF; // jal  x1,16
  localparam logic [31:0] I_AUIPC  = 32'h00001397; // auipc x7,1
  localparam logic [31:0] I_ECALL  = 32'h00000073;
  localparam logic [31:0] I_ADDIM1 = 32'hFFF00313; // addi x6,x0,-1
  localparam logic [31:0] I_ILL    = 32'h0000007F;
  localparam logic [31:0] I_ADDX0  = 32'h00208033; // add  x0,x1,x2

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [9:0]  ctl;
    logic [2:0]  f3;
    bit   [5:0]  m;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input string name, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [3:0] alu, input logic [1:0] src, input logic [9:0] ctl,
                              input logic [2:0] f3, input bit [5:0] m);
    exp_t e;
    e.name = name; e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.alu = alu; e.src = src; e.ctl = ctl; e.f3 = f3; e.m = m;
    sbq.push_back(e);
  endtask

  // Hold an instruction in D until the stage accepts it; count stall cycles.
  task automatic present(input string name, input logic [31:0] ins, input logic [31:0] pc,
                         input int exp_stalls);
    int stalls = 0;
    Instr_D = ins; PC_D = pc; InstrValid_D = 1'b1;
    @(negedge clk);
    while (Stall_D && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk({name, "_stalls"}, stalls, exp_stalls);
    @(posedge clk); #1;
    InstrValid_D = 1'b0;
  endtask

  // Monitor: every issued instruction must match the head of the scoreboard;
  // every bubble must carry no enables.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (Valid_E) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue: pc 0x%0h issued, nothing expected", PC_E);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_pc"}, PC_E, e.pc);
          chk({e.name, "_ctl"}, ctl_now, e.ctl);
          if (e.m[5]) chk({e.name, "_imm"}, Imm_E, e.imm);
          if (e.m[4]) chk({e.name, "_alu"}, {ALUCtrl_E, ALUSrcA_E, ALUSrcB_E}, {e.alu, e.src});
          if (e.m[3]) chk({e.name, "_rs1"}, Rs1_E, e.rs1);
          if (e.m[2]) chk({e.name, "_rs2"}, Rs2_E, e.rs2);
          if (e.m[1]) chk({e.name, "_rd"}, Rd_E, e.rd);
          if (e.m[0]) chk({e.name, "_f3"}, Funct3_E, e.f3);
        end
      end else begin
        chk("bubble_ctl", ctl_now, 10'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a valid ADDI waiting in D: nothing may reach E.
    rst = 1'b0; InstrValid_D = 1'b1; Instr_D = I_ADDI1; PC_D = 32'h100;
    Flush_E = 1'b0; Resume = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", Stall_D, 1'b0);
    chk("rst_valid", Valid_E, 1'b0);
    chk("rst_pc", PC_E, 32'd0);
    chk("rst_imm", Imm_E, 32'd0);
    chk("rst_fields", {Rs1_E, Rs2_E, Rd_E, ALUCtrl_E, ALUSrcA_E, ALUSrcB_E, Funct3_E, ctl_now}, 64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; InstrValid_D = 1'b0;

    // Plain issue and field decode.
    expect_issue("addi", 32'h100, 32'd5, 5'd0, 5'd0, 5'd1, 4'd0, 2'b01, 10'b0010000000, 3'd0,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("addi", I_ADDI1, 32'h100, 0);

    // Load-use via rs1/rs2 of an OP.
    expect_issue("lw_a", 32'h104, 32'd0, 5'd1, 5'd0, 5'd2, 4'd0, 2'b01, 10'b1010100000, 3'd2,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("lw_a", I_LW, 32'h104, 0);
    expect_issue("add", 32'h108, 32'd0, 5'd2, 5'd2, 5'd3, 4'd0, 2'b00, 10'b0010000000, 3'd0,
                 M_ALU | M_RS1 | M_RS2 | M_RD | M_F3);
    present("add", I_ADD, 32'h108, 1);

    // Load-use via the store data register.
    expect_issue("lw_b", 32'h10C, 32'd0, 5'd1, 5'd0, 5'd2, 4'd0, 2'b01, 10'b1010100000, 3'd2,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("lw_b", I_LW, 32'h10C, 0);
    expect_issue("sw", 32'h110, 32'd0, 5'd0, 5'd2, 5'd0, 4'd0, 2'b01, 10'b0100000000, 3'd2,
                 M_IMM | M_ALU | M_RS1 | M_RS2 | M_F3);
    present("sw", I_SW, 32'h110, 1);

    // LUI's rs1 field matches the load rd but LUI reads no register.
    expect_issue("lw_c", 32'h114, 32'd0, 5'd1, 5'd0, 5'd2, 4'd0, 2'b01, 10'b1010100000, 3'd2,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("lw_c", I_LW, 32'h114, 0);
    expect_issue("lui", 32'h118, 32'h00011000, 5'd0, 5'd0, 5'd2, 4'd10, 2'b01, 10'b0010000000, 3'd0,
                 M_IMM | M_ALU | M_RD);
    present("lui", I_LUI, 32'h118, 0);

    // Further formats and ALU selections.
    expect_issue("sub", 32'h11C, 32'd0, 5'd1, 5'd2, 5'd4, 4'd1, 2'b00, 10'b0010000000, 3'd0,
                 M_ALU | M_RS1 | M_RS2 | M_RD | M_F3);
    present("sub", I_SUB, 32'h11C, 0);
    expect_issue("srai", 32'h120, 32'h403, 5'd1, 5'd0, 5'd5, 4'd7, 2'b01, 10'b0010000000, 3'd5,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("srai", I_SRAI, 32'h120, 0);
    expect_issue("beq", 32'h124, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0, 4'd0, 2'b00, 10'b0000010000, 3'd0,
                 M_IMM | M_RS1 | M_RS2 | M_F3);
    present("beq", I_BEQ, 32'h124, 0);
    expect_issue("jal", 32'h128, 32'd16, 5'd0, 5'd0, 5'd1, 4'd0, 2'b00, 10'b0011001000, 3'd0,
                 M_IMM | M_RD);
    present("jal", I_JAL, 32'h128, 0);
    expect_issue("auipc", 32'h12C, 32'h00001000, 5'd0, 5'd0, 5'd7, 4'd0, 2'b11, 10'b0010000000, 3'd0,
                 M_IMM | M_ALU | M_RD);
    present("auipc", I_AUIPC, 32'h12C, 0);

    // Flush in the hazard cycle wins over the stall.
    expect_issue("lw_d", 32'h140, 32'd0, 5'd1, 5'd0, 5'd2, 4'd0, 2'b01, 10'b1010100000, 3'd2,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("lw_d", I_LW, 32'h140, 0);
    Instr_D = I_ADD; PC_D = 32'h144; InstrValid_D = 1'b1; Flush_E = 1'b1;
    @(negedge clk);
    chk("flush_hz_stall", Stall_D, 1'b0);
    @(posedge clk); #1;
    Flush_E = 1'b0; InstrValid_D = 1'b0;
    @(negedge clk);
    chk("flush_hz_valid", Valid_E, 1'b0);
    @(posedge clk); #1;

    // Flush on a plain instruction kills it.
    Instr_D = I_ADDI1; PC_D = 32'h148; InstrValid_D = 1'b1; Flush_E = 1'b1;
    @(negedge clk);
    chk("flush_addi_stall", Stall_D, 1'b0);
    @(posedge clk); #1;
    Flush_E = 1'b0; InstrValid_D = 1'b0;
    @(negedge clk);
    chk("flush_addi_valid", Valid_E, 1'b0);
    @(posedge clk); #1;

    // ECALL halts; Resume after five halted cycles issues the waiting op.
    expect_issue("ecall", 32'h150, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 10'b0000000010, 3'd0, 6'd0);
    present("ecall", I_ECALL, 32'h150, 0);
    Instr_D = I_ADDIM1; PC_D = 32'h154; InstrValid_D = 1'b1;
    expect_issue("addi_m1", 32'h154, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd6, 4'd0, 2'b01, 10'b0010000000, 3'd0,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_stall", Stall_D, 1'b1);
      if (i > 0) chk("halt_bubble", Valid_E, 1'b0);
      @(posedge clk); #1;
    end
    Resume = 1'b1;
    @(negedge clk);
    chk("resume_stall", Stall_D, 1'b0);
    @(posedge clk); #1;
    Resume = 1'b0; InstrValid_D = 1'b0;
    @(negedge clk);
    chk("resume_issue", Valid_E, 1'b1);
    @(posedge clk); #1;

    // Reset while halted returns to RUN with an empty E slot.
    expect_issue("ecall2", 32'h158, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 10'b0000000010, 3'd0, 6'd0);
    present("ecall2", I_ECALL, 32'h158, 0);
    Instr_D = I_ADDI1; PC_D = 32'h15C; InstrValid_D = 1'b1;
    @(negedge clk);
    chk("halt2_stall", Stall_D, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_halt_stall", Stall_D, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; InstrValid_D = 1'b0;
    @(negedge clk);
    chk("rst_halt_valid", Valid_E, 1'b0);
    @(posedge clk); #1;
    expect_issue("addi_post_rst", 32'h15C, 32'd5, 5'd0, 5'd0, 5'd1, 4'd0, 2'b01, 10'b0010000000, 3'd0,
                 M_IMM | M_ALU | M_RS1 | M_RD | M_F3);
    present("addi_post_rst", I_ADDI1, 32'h15C, 0);

    // Illegal opcode halts with enables low; then ADD to x0 must not write.
    expect_issue("illegal", 32'h160, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 10'b0000000001, 3'd0, 6'd0);
    present("illegal", I_ILL, 32'h160, 0);
    @(negedge clk);
    chk("ill_halt_stall", Stall_D, 1'b1);
    @(posedge clk); #1;
    Resume = 1'b1;
    @(posedge clk); #1;
    Resume = 1'b0;
    expect_issue("add_x0", 32'h164, 32'd0, 5'd1, 5'd2, 5'd0, 4'd0, 2'b00, 10'b0000000000, 3'd0,
                 M_ALU | M_RS1 | M_RS2 | M_RD | M_F3);
    present("add_x0", I_ADDX0, 32'h164, 0);

    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
